// File: rtl/stopwatch_pkg.sv
// Shared types and elaboration-time helpers for the stopwatch timekeeping core.
package stopwatch_pkg;

    typedef enum logic [1:0] {RUN, PAUSED, ADJUST} state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    function automatic int unsigned div_of(input int unsigned clk_hz, input int unsigned rate_hz);
        return clk_hz / rate_hz;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    function automatic bcd_t to_bcd(input int unsigned n);
        bcd_t b;
        b.tens = 4'((n / 10) % 10);
        b.ones = 4'(n % 10);
        return b;
    endfunction

    // Increment a two-digit BCD value, rolling over to 00 after lim.
    function automatic bcd_t bcd_inc(input bcd_t v, input bcd_t lim);
        bcd_t r;
        if (v == lim) begin
            r = '0;
        end else if (v.ones == 4'd9) begin
            r.tens = v.tens + 4'd1;
            r.ones = '0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Integer prescaler: one-cycle tick every DIV enabled cycles, with synchronous clear.
module tick_gen
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    W    = cnt_width(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("tick_gen: divisor must be at least 2");
    end

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch core with run/pause/adjust control, lap capture and wrap pulse.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned ADJ_HZ   = 2,
    parameter int unsigned BLINK_HZ = 4,
    parameter int unsigned MAX_MIN  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_p,
    input  logic       clr_p,
    input  logic       lap_p,
    input  logic       adj,
    input  logic       sel,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] lap_min_bcd,
    output logic [7:0] lap_sec_bcd,
    output logic       lap_valid,
    output logic       running,
    output logic       adjusting,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       wrap
);

    localparam int unsigned CNT_DIV   = div_of(CLK_HZ, TICK_HZ);
    localparam int unsigned ADJ_DIV   = div_of(CLK_HZ, ADJ_HZ);
    localparam int unsigned BLINK_DIV = div_of(CLK_HZ, 2 * BLINK_HZ);
    localparam bcd_t        MIN_MAX   = to_bcd(MAX_MIN);
    localparam bcd_t        SEC_MAX   = to_bcd(59);

    if (MAX_MIN < 1 || MAX_MIN > 99) begin : g_max_chk
        $error("stopwatch_core: MAX_MIN must be in 1..99");
    end

    state_t state, state_nx, resume, resume_nx;
    bcd_t   min_q, sec_q, min_nx, sec_nx, lap_min_q, lap_sec_q;
    logic   wrap_nx, phase, phase_nx;
    logic   cnt_tick, adj_tick, blink_tick;

    tick_gen #(.DIV(CNT_DIV)) u_cnt_tick (
        .clk(clk), .rst(rst), .en(state == RUN), .clr(clr_p), .tick(cnt_tick)
    );

    // Adjust and blink prescalers sit cleared outside ADJUST so both restart on entry.
    tick_gen #(.DIV(ADJ_DIV)) u_adj_tick (
        .clk(clk), .rst(rst), .en(state == ADJUST), .clr(state != ADJUST), .tick(adj_tick)
    );

    tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk(clk), .rst(rst), .en(state == ADJUST), .clr(state != ADJUST), .tick(blink_tick)
    );

    always_comb begin
        state_nx  = state;
        resume_nx = resume;
        case (state)
            RUN, PAUSED: begin
                if (adj) begin
                    state_nx  = ADJUST;
                    resume_nx = state;
                end else if (pause_p) begin
                    state_nx = (state == RUN) ? PAUSED : RUN;
                end
            end
            ADJUST:  if (!adj) state_nx = resume;
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        min_nx  = min_q;
        sec_nx  = sec_q;
        wrap_nx = 1'b0;
        if (clr_p) begin
            min_nx = '0;
            sec_nx = '0;
        end else if (state == ADJUST) begin
            if (adj_tick) begin
                if (sel) sec_nx = bcd_inc(sec_q, SEC_MAX);
                else     min_nx = bcd_inc(min_q, MIN_MAX);
            end
        end else if (cnt_tick) begin
            sec_nx = bcd_inc(sec_q, SEC_MAX);
            if (sec_q == SEC_MAX) begin
                min_nx  = bcd_inc(min_q, MIN_MAX);
                wrap_nx = (min_q == MIN_MAX);
            end
        end
    end

    always_comb begin
        phase_nx = 1'b0;
        if (state == ADJUST && state_nx == ADJUST) phase_nx = phase ^ blink_tick;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            resume    <= RUN;
            min_q     <= '0;
            sec_q     <= '0;
            lap_min_q <= '0;
            lap_sec_q <= '0;
            lap_valid <= 1'b0;
            wrap      <= 1'b0;
            phase     <= 1'b0;
            blank_min <= 1'b0;
            blank_sec <= 1'b0;
        end else begin
            state     <= state_nx;
            resume    <= resume_nx;
            min_q     <= min_nx;
            sec_q     <= sec_nx;
            wrap      <= wrap_nx;
            phase     <= phase_nx;
            blank_min <= (state_nx == ADJUST) && !sel && phase_nx;
            blank_sec <= (state_nx == ADJUST) &&  sel && phase_nx;
            if (clr_p) begin
                lap_min_q <= '0;
                lap_sec_q <= '0;
                lap_valid <= 1'b0;
            end else if (lap_p) begin
                lap_min_q <= min_q;
                lap_sec_q <= sec_q;
                lap_valid <= 1'b1;
            end
        end
    end

    assign min_bcd     = min_q;
    assign sec_bcd     = sec_q;
    assign lap_min_bcd = lap_min_q;
    assign lap_sec_bcd = lap_sec_q;
    assign running     = (state == RUN);
    assign adjusting   = (state == ADJUST);

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: 100 Hz clock, 10 Hz count, 5 Hz adjust, 10 Hz blink, MAX_MIN=2.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_p = 1'b0, clr_p = 1'b0, lap_p = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [7:0] min_bcd, sec_bcd, lap_min_bcd, lap_sec_bcd;
    logic       lap_valid, running, adjusting, blank_min, blank_sec, wrap;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned bad_digits = 0;

    always #5 clk = ~clk;

    stopwatch_core #(
        .CLK_HZ(100), .TICK_HZ(10), .ADJ_HZ(5), .BLINK_HZ(10), .MAX_MIN(2)
    ) dut (
        .clk(clk), .rst(rst), .pause_p(pause_p), .clr_p(clr_p), .lap_p(lap_p),
        .adj(adj), .sel(sel), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .lap_min_bcd(lap_min_bcd), .lap_sec_bcd(lap_sec_bcd), .lap_valid(lap_valid),
        .running(running), .adjusting(adjusting), .blank_min(blank_min),
        .blank_sec(blank_sec), .wrap(wrap)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance n active edges, then sample 1 time unit later.
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic p, input logic c, input logic l);
        pause_p = p; clr_p = c; lap_p = l;
        step(1);
        pause_p = 1'b0; clr_p = 1'b0; lap_p = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        check_eq("rst_min", min_bcd, 8'h00);
        check_eq("rst_sec", sec_bcd, 8'h00);
        check_eq("rst_lap_valid", lap_valid, 0);
        check_eq("rst_running", running, 1);
        check_eq("rst_adjusting", adjusting, 0);
        check_eq("rst_blank", {blank_min, blank_sec, wrap}, 0);
        #1 rst = 1'b1;

        for (int i = 0; i < 599; i++) begin
            step(1);
            if (sec_bcd[3:0] > 4'd9 || sec_bcd > 8'h59) bad_digits++;
        end
        check_eq("t599_min", min_bcd, 8'h00);
        check_eq("t599_sec", sec_bcd, 8'h59);
        step(1);
        check_eq("t600_min", min_bcd, 8'h01);
        check_eq("t600_sec", sec_bcd, 8'h00);
        check_eq("sec_digits_legal", 8'(bad_digits), 8'h00);

        step(1190);
        check_eq("pre_wrap_time", {min_bcd, sec_bcd} == 16'h0259, 1);
        check_eq("pre_wrap_flag", wrap, 0);
        step(10);
        check_eq("wrap_time", {min_bcd, sec_bcd} == 16'h0000, 1);
        check_eq("wrap_flag", wrap, 1);
        step(1);
        check_eq("wrap_one_cycle", wrap, 0);

        pulse(0, 1, 0);
        step(50);
        check_eq("run_to_05", sec_bcd, 8'h05);
        pulse(1, 0, 0);
        check_eq("paused_running", running, 0);
        step(100);
        check_eq("pause_hold_sec", sec_bcd, 8'h05);
        check_eq("pause_hold_running", running, 0);
        pulse(1, 0, 0);
        check_eq("resume_running", running, 1);
        step(8);
        check_eq("resume_pre_tick", sec_bcd, 8'h05);
        step(1);
        check_eq("resume_tick_held_prescaler", sec_bcd, 8'h06);

        pulse(1, 0, 0);
        adj = 1'b1; sel = 1'b0;
        step(1);
        check_eq("adj_entry_adjusting", adjusting, 1);
        check_eq("adj_entry_running", running, 0);
        step(4);
        check_eq("blink_min_e4", blank_min, 0);
        step(1);
        check_eq("blink_min_e5", blank_min, 1);
        check_eq("blink_sec_unsel", blank_sec, 0);
        step(5);
        check_eq("blink_min_e10", blank_min, 0);
        step(9);
        check_eq("adj_min_e19", min_bcd, 8'h00);
        step(1);
        check_eq("adj_min_e20", min_bcd, 8'h01);
        step(20);
        check_eq("adj_min_e40", min_bcd, 8'h02);
        check_eq("adj_sec_untouched", sec_bcd, 8'h06);
        adj = 1'b0;
        step(1);
        check_eq("adj_exit_adjusting", adjusting, 0);
        check_eq("adj_exit_to_paused", running, 0);
        check_eq("adj_exit_blank", blank_min, 0);

        adj = 1'b1; sel = 1'b1;
        step(1);
        step(1040);
        check_eq("adj_sec_58", sec_bcd, 8'h58);
        step(5);
        check_eq("blink_sec_sel", blank_sec, 1);
        check_eq("blink_min_unsel", blank_min, 0);
        step(55);
        check_eq("adj_sec_wrap_01", sec_bcd, 8'h01);
        check_eq("adj_sec_no_carry", min_bcd, 8'h02);
        pulse(1, 0, 0);
        adj = 1'b0;
        step(1);
        check_eq("pause_ignored_in_adj", running, 0);

        pulse(0, 1, 0);
        check_eq("clr_paused_time", {min_bcd, sec_bcd} == 16'h0000, 1);
        check_eq("clr_keeps_paused", running, 0);
        pulse(1, 0, 0);
        step(69);
        check_eq("lap_pre_sec", sec_bcd, 8'h06);
        pulse(0, 0, 1);
        check_eq("lap_sec_pre_update", lap_sec_bcd, 8'h06);
        check_eq("lap_min", lap_min_bcd, 8'h00);
        check_eq("lap_valid_set", lap_valid, 1);
        check_eq("lap_edge_time", sec_bcd, 8'h07);
        pulse(0, 1, 0);
        check_eq("clr_time", {min_bcd, sec_bcd} == 16'h0000, 1);
        check_eq("clr_lap", lap_sec_bcd, 8'h00);
        check_eq("clr_lap_valid", lap_valid, 0);
        check_eq("clr_keeps_run", running, 1);
        pulse(0, 0, 1);
        check_eq("lap_again_valid", lap_valid, 1);
        pulse(0, 1, 1);
        check_eq("lap_clr_valid", lap_valid, 0);
        check_eq("lap_clr_sec", sec_bcd, 8'h00);
        step(9);
        pulse(1, 0, 0);
        check_eq("tick_with_pause_sec", sec_bcd, 8'h01);
        check_eq("tick_with_pause_state", running, 0);
        pulse(0, 0, 1);

        #3 rst = 1'b0;
        #1;
        check_eq("async_rst_sec", sec_bcd, 8'h00);
        check_eq("async_rst_running", running, 1);
        check_eq("async_rst_lap_valid", lap_valid, 0);
        check_eq("async_rst_lap_sec", lap_sec_bcd, 8'h00);
        #1 rst = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
